// File: rtl/ofifo_pkg.sv
// Shared constants, pointer-width helper and pointer type for the
// multi-lane output FIFO.
package ofifo_pkg;

  localparam int COL_DEF   = 8;
  localparam int BW_DEF    = 4;
  localparam int DEPTH_DEF = 64;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int AW_DEF = ptr_w(DEPTH_DEF);

  typedef logic [AW_DEF:0] ptr_def_t;

endpackage

// File: rtl/ofifo_lane.sv
// One column lane: storage, wrap-bit pointers, full/empty and occupancy.
// A write to a full lane is taken only when the same cycle pops it.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          pop,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  typedef logic [AW:0] ptr_t;

  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic [BW-1:0] mem [DEPTH];
  logic          wr_en;

  assign wr_en = wr & (~o_full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)
        rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // storage is never cleared; only the pointers define contents
  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout    = mem[rd_ptr[AW-1:0]];
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;

endmodule

// File: rtl/ofifo_multi_lane.sv
// Multi-lane output FIFO: independent column writes, whole-row pops.
// Optional sticky err_ovf/err_udf ports under OFIFO_ERR_FLAGS_EN.
module ofifo_multi_lane
  import ofifo_pkg::*;
#(
  parameter int COL       = COL_DEF,
  parameter int BW        = BW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_MARGIN = 2,
  localparam int AW       = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL-1:0]    wr,
  input  logic [BW*COL-1:0] in,
  input  logic              rd,
  output logic [BW*COL-1:0] out,
  output logic              out_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid,
`ifdef OFIFO_ERR_FLAGS_EN
  output logic              err_ovf,
  output logic              err_udf,
`endif
  output logic [AW:0]       o_level
);

  localparam logic [AW:0] AF_LIM = (AW+1)'(DEPTH - AF_MARGIN - 1);

  logic [COL-1:0]    full;
  logic [COL-1:0]    empty;
  logic [AW:0]       cnt [COL];
  logic [BW*COL-1:0] row;
  logic              pop;

  assign pop = rd & o_valid;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    ofifo_lane #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .pop     (pop),
      .din     (in[BW*i +: BW]),
      .dout    (row[BW*i +: BW]),
      .o_full  (full[i]),
      .o_empty (empty[i]),
      .o_count (cnt[i])
    );
  end

  assign o_full  = |full;
  assign o_valid = ~|empty;

  always_comb begin
    o_ready = 1'b1;
    o_level = cnt[0];
    for (int i = 0; i < COL; i++) begin
      if (cnt[i] > AF_LIM)
        o_ready = 1'b0;
      if (cnt[i] < o_level)
        o_level = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop)
        out <= row;
    end
  end

`ifdef OFIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (|(wr & full & ~{COL{pop}}))
        err_ovf <= 1'b1;
      if (rd && !o_valid)
        err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofifo_multi_lane.sv
// Directed self-checking bench for ofifo_multi_lane (default parameters).
module tb_ofifo_multi_lane;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr;
  logic [31:0] in;
  logic        rd;
  logic [31:0] out;
  logic        out_valid;
  logic        o_full;
  logic        o_ready;
  logic        o_valid;
  logic [6:0]  o_level;
`ifdef OFIFO_ERR_FLAGS_EN
  logic        err_ovf;
  logic        err_udf;
`endif

  int pass  = 0;
  int total = 0;

  ofifo_multi_lane dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (in),
    .rd        (rd),
    .out       (out),
    .out_valid (out_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
`ifdef OFIFO_ERR_FLAGS_EN
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
`endif
    .o_level   (o_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rep(input logic [3:0] v);
    return {8{v}};
  endfunction

  function automatic logic [31:0] rowv(input int j);
    logic [31:0] v;
    for (int i = 0; i < 8; i++)
      v[4*i +: 4] = 4'(j + i);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++; if (o_full !== 1'b0) $display("FAIL rst_full got %b want 0", o_full); else pass++;
    total++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_ready); else pass++;
    total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_valid); else pass++;
    total++; if (o_level !== 7'd0) $display("FAIL rst_level got %0d want 0", o_level); else pass++;
    total++; if (out !== 32'h0) $display("FAIL rst_out got %h want 0", out); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_ovalid got %b want 0", out_valid); else pass++;
  endtask

  task automatic test_staggered();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      wr = '0; in = '0;
      for (int i = 0; i < 8; i++)
        if (t >= i && t < i + 3) begin
          wr[i] = 1'b1;
          in[4*i +: 4] = 4'(t - i + 1);
        end
      step();
      total++;
      if (o_valid !== (t >= 7))
        $display("FAIL stag_valid t=%0d got %b want %b", t, o_valid, t >= 7);
      else pass++;
    end
    wr = '0; in = '0;
    total++; if (o_level !== 7'd3) $display("FAIL stag_level got %0d want 3", o_level); else pass++;
    for (int r = 1; r <= 3; r++) begin
      rd = 1'b1;
      step();
      rd = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out !== rep(4'(r)))
        $display("FAIL stag_pop%0d got %b/%h want 1/%h", r, out_valid, out, rep(4'(r)));
      else pass++;
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out !== 32'h33333333)
      $display("FAIL stag_rd4 got %b/%h want 0/33333333", out_valid, out);
    else pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      wr = 8'h01; in = 32'(k & 15);
      step();
      if (k == 61 || k == 62) begin
        total++;
        if (o_ready !== (k == 61))
          $display("FAIL full_ready k=%0d got %b want %b", k, o_ready, k == 61);
        else pass++;
      end
      if (k == 63 || k == 64) begin
        total++;
        if (o_full !== (k == 64))
          $display("FAIL full_flag k=%0d got %b want %b", k, o_full, k == 64);
        else pass++;
      end
    end
    wr = '0;
    total++; if (o_level !== 7'd0) $display("FAIL full_level got %0d want 0", o_level); else pass++;
    total++;
    if (dut.g_lane[0].u_lane.o_count !== 7'd64)
      $display("FAIL full_cnt got %0d want 64", dut.g_lane[0].u_lane.o_count);
    else pass++;
    total++; if (o_full !== 1'b1) $display("FAIL full_hold got %b want 1", o_full); else pass++;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 0; k < 64; k++) begin
      wr = 8'hFF; in = rep(4'(k + 1));
      step();
    end
    total++;
    if (o_full !== 1'b1 || o_level !== 7'd64)
      $display("FAIL fp_fill got %b/%0d want 1/64", o_full, o_level);
    else pass++;
    wr = 8'hFF; in = 32'hAAAAAAAA; rd = 1'b1;
    step();
    wr = '0; in = '0;
    total++;
    if (out_valid !== 1'b1 || out !== 32'h11111111)
      $display("FAIL fp_pop got %b/%h want 1/11111111", out_valid, out);
    else pass++;
    total++;
    if (o_full !== 1'b1 || o_level !== 7'd64)
      $display("FAIL fp_flags got %b/%0d want 1/64", o_full, o_level);
    else pass++;
    for (int j = 1; j <= 64; j++) begin
      logic [31:0] e;
      e = (j == 64) ? 32'hAAAAAAAA : rep(4'(j + 1));
      step();
      total++;
      if (out_valid !== 1'b1 || out !== e)
        $display("FAIL fp_drain%0d got %b/%h want 1/%h", j, out_valid, out, e);
      else pass++;
    end
    rd = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL fp_empty got %b want 0", o_valid); else pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int j = 0; j <= 200; j++) begin
      wr = (j < 200) ? 8'hFF : 8'h00;
      in = rowv(j);
      rd = 1'b1;
      step();
      total++;
      if (o_level > 7'd1) $display("FAIL wrap_level j=%0d got %0d want <=1", j, o_level);
      else pass++;
      if (j > 0) begin
        total++;
        if (out_valid !== 1'b1 || out !== rowv(j - 1))
          $display("FAIL wrap_row%0d got %b/%h want 1/%h", j - 1, out_valid, out, rowv(j - 1));
        else pass++;
      end
    end
    wr = '0; rd = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL wrap_empty got %b want 0", o_valid); else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd = 1'b1;
    step();
    rd = 1'b0;
    for (int k = 0; k < 65; k++) begin
      wr = 8'h01; in = 32'h5;
      step();
    end
    for (int k = 0; k < 10; k++) begin
      wr = 8'hFE; in = rowv(k);
      step();
    end
    wr = '0;
    total++; if (o_level !== 7'd10) $display("FAIL mid_level got %0d want 10", o_level); else pass++;
`ifdef OFIFO_ERR_FLAGS_EN
    total++;
    if (err_ovf !== 1'b1 || err_udf !== 1'b1)
      $display("FAIL mid_errset got %b%b want 11", err_ovf, err_udf);
    else pass++;
`endif
    reset = 1'b1; rd = 1'b1;
    step();
    reset = 1'b0; rd = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_ovalid got %b want 0", out_valid); else pass++;
    total++; if (o_level !== 7'd0) $display("FAIL mid_level0 got %0d want 0", o_level); else pass++;
    total++; if (o_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", o_valid); else pass++;
`ifdef OFIFO_ERR_FLAGS_EN
    total++;
    if (err_ovf !== 1'b0 || err_udf !== 1'b0)
      $display("FAIL mid_errclr got %b%b want 00", err_ovf, err_udf);
    else pass++;
`endif
  endtask

  initial begin
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    test_reset();
    test_staggered();
    test_full();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/ofifo_multi_lane.md
Name: ofifo_multi_lane

Overview:
- Parametrised output FIFO that collects per-column results from the PE array's bottom row, one lane per column.
- Columns write independently. A whole row (one word from every lane) pops only once every lane holds data.
- Generalises the fixed 64-deep output FIFO:
  - configurable depth,
  - almost-full back-pressure margin,
  - row-count level output,
  - registered output with explicit output-valid.
- Sits between the MAC array outputs and the SFU/PSUM write-back path.

Parameters:
- COL, 8, number of lanes (array columns).
- BW, 4, bits per lane word.
- DEPTH, 64, entries per lane; power of 2, min 4.
- AF_MARGIN, 2, free-entry margin that deasserts o_ready; 1..DEPTH-1.

Ports:
- clk  input  1  single clock, all logic posedge.
- reset  input  1  synchronous reset, active-high; sampled on posedge clk.
- wr  input  COL  per-lane write strobe.
- in  input  BW*COL  lane i data on in[BW*i +: BW].
- rd  input  1  row pop request.
- out  output  BW*COL  registered popped row; lane i on out[BW*i +: BW].
- out_valid  output  1  out holds a freshly popped row this cycle.
- o_full  output  1  at least one lane full.
- o_ready  output  1  every lane has more than AF_MARGIN free entries.
- o_valid  output  1  every lane non-empty; a row can be popped.
- o_level  output  $clog2(DEPTH)+1  minimum lane occupancy, i.e. complete rows available.

Behaviour:
- Lane state:
  - wr_ptr and rd_ptr, each AW+1 bits, where AW = $clog2(DEPTH); storage is addressed by ptr[AW-1:0].
  - Full when pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - Pointers wrap naturally mod 2*DEPTH.
- Reset (synchronous):
  - All pointers 0, out = 0, out_valid = 0.
  - Flags then read o_full = 0, o_ready = 1, o_valid = 0, o_level = 0.
  - Storage is not cleared.
  - Reset mid-operation discards all buffered data; any simultaneous wr/rd in the reset cycle is ignored.
- Pop:
  - A pop is accepted iff rd && o_valid. All lanes advance rd_ptr in the same cycle.
  - out is loaded with the head of every lane; out_valid = 1 on the next cycle (1-cycle latency).
  - rd with o_valid = 0 is ignored: out holds its previous value, out_valid = 0.
  - out_valid is 0 in any cycle not following an accepted pop. out holds its value until the next pop.
- Write:
  - wr[i] writes in lane i at wr_ptr and increments it when lane i is not full.
  - Write to a full lane is dropped, except when a pop is accepted in the same cycle. In that case the write is accepted and the lane stays full.
  - Simultaneous write and pop on a non-full lane: both occur, occupancy unchanged.
  - A pop never returns data written in the same cycle. A write into an empty lane is poppable from the next cycle.
- Flags:
  - Combinational from registered pointers only; no dependence on same-cycle wr/rd.
  - o_ready = 0 iff any lane occupancy > DEPTH - AF_MARGIN - 1.
  - o_level = min over lanes of (wr_ptr - rd_ptr), mod 2*DEPTH.

Optional Feature:
- Macro OFIFO_ERR_FLAGS_EN adds two sticky output ports:
  - err_ovf (1 bit): set when any write to a full lane is dropped.
  - err_udf (1 bit): set when rd is asserted while o_valid = 0.
- Both flags clear only on reset.
- Without the macro, neither port exists, and dropped writes and ignored reads are silent.

Decomposition:
- Shared package ofifo_pkg:
  - Function for pointer width (clog2).
  - Lane pointer typedef parameterised via AW.
  - Default constants COL_DEF = 8, BW_DEF = 4, DEPTH_DEF = 64.
- One sub-module, ofifo_lane:
  - One lane's storage, pointers, full/empty and occupancy.
  - Ports: clk, reset, wr, pop, din, dout, o_full, o_empty, o_count.
- Top generates COL lanes and adds:
  - pop qualification,
  - output register,
  - flag reduction,
  - min-level tree.

Test Plan:
- Reset, then idle: o_full = 0, o_ready = 1, o_valid = 0, o_level = 0, out = 0, out_valid = 0.
- Staggered lane writes, then row pop:
  - Stimulus: 3 words per lane, lane i delayed by i cycles; values 0x1, 0x2, 0x3 in every lane.
  - o_valid rises only once lane 7 has written its first word.
  - rd pops 3 rows; out = 0x11111111, 0x22222222, 0x33333333, each with out_valid one cycle after rd.
  - A 4th rd is ignored with out_valid = 0.
- Full and back-pressure, with DEPTH = 64 and AF_MARGIN = 2, writing lane 0 only:
  - o_ready drops after the 62nd write; o_full rises after the 64th.
  - The 65th write is dropped: o_level stays 0 because the other lanes are empty, and lane 0 count stays 64.
- Full with simultaneous pop:
  - All lanes full, wr = 0xFF and rd in the same cycle.
  - Row popped, new row accepted, o_full stays 1, o_level = 64.
- Pointer wrap: stream 200 rows at one write and one pop per cycle. Output order is exact, no loss, o_level ≤ 1 throughout.
- Reset mid-stream: with o_level = 10, assert reset together with rd. out_valid = 0 next cycle, o_level = 0; with OFIFO_ERR_FLAGS_EN, err_ovf and err_udf are cleared.
